uart_tx_serializer: RTL and testbench

UART transmit framing stage. It sits directly downstream of the Tx bit-rate pulse counter and consumes that counter's end-of-bit pulse. It accepts a parallel byte through a start/busy handshake and shifts out start, data (LSB first), optional parity and stop bits on a registered serial line. It also drives the counter's enable and clear inputs, so every frame begins with a full-length start bit.

---
 rtl/uart_tx_serializer.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit framing stage: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 end_bit_time,
   output logic                 bit_en,
   output logic                 bit_clr,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int IDX_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 en_q, en_d;
   logic                 clr_q, clr_d;
   logic                 bit_end_s;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`else
   localparam bit unused_parity_odd = PARITY_ODD;
`endif

   assign bit_end_s = (state_q != S_IDLE) && en_q && end_bit_time;

   // Next-state, datapath and registered-output values; outputs follow the next state.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      clr_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               state_d = S_START;
               shift_d = tx_data;
               clr_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
               par_d   = (^tx_data) ^ PARITY_ODD;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               state_d = S_DATA;
               idx_d   = {IDX_W{1'b0}};
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
                  stop_d  = 1'b0;
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 4'd1;
               end
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end_s) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
            end else begin
               state_d = S_PARITY;
            end
         end
`endif
         S_STOP: begin
            if (bit_end_s) begin
               if (stop_q == LAST_STOP) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_d  = stop_q + 1'b1;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE);
      en_d   = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= {DATA_BITS{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         clr_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         en_q    <= en_d;
         clr_q   <= clr_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;
   assign bit_en  = en_q;
   assign bit_clr = clr_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: one-stop and two-stop instances driven by a
// bit-rate counter model with limit 3 (4 clocks per bit).
module tb_uart_tx_serializer;

   localparam logic [1:0] LIMIT      = 2'd3;
   localparam bit         PARITY_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FLEN1 = 1 + 8 + P + 1;
   localparam int FLEN2 = 1 + 8 + P + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic spur = 1'b0;

   logic       tx_start = 1'b0, tx_start2 = 1'b0;
   logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
   logic       bit_en, bit_clr, tx, tx_busy, tx_done, end_bit;
   logic       bit_en2, bit_clr2, tx2, tx_busy2, tx_done2, end_bit2;
   logic [1:0] cnt = 2'd0, cnt2 = 2'd0, eff, eff2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PARITY_ODD)) u_dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .end_bit_time(end_bit),
      .bit_en(bit_en), .bit_clr(bit_clr), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(PARITY_ODD)) u_dut2 (
      .clk(clk), .rst(rst), .tx_start(tx_start2), .tx_data(tx_data2), .end_bit_time(end_bit2),
      .bit_en(bit_en2), .bit_clr(bit_clr2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
   );

   // Bit-rate counter model: the clear cycle counts as count 0 of the new bit.
   assign eff      = bit_clr ? 2'd0 : cnt;
   assign end_bit  = (bit_en && eff == LIMIT) || spur;
   assign eff2     = bit_clr2 ? 2'd0 : cnt2;
   assign end_bit2 = bit_en2 && eff2 == LIMIT;

   always_ff @(posedge clk) begin
      if (rst || !bit_en || eff == LIMIT) cnt <= 2'd0;
      else                                cnt <= eff + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst || !bit_en2 || eff2 == LIMIT) cnt2 <= 2'd0;
      else                                  cnt2 <= eff2 + 2'd1;
   end

   typedef struct {
      string      name;
      logic [7:0] data;
      logic       par_even;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] build_frame(input logic [7:0] d, input logic pe);
      logic [15:0] f;
      f    = 16'hFFFF;
      f[0] = 1'b0;
      for (int k = 0; k < 8; k++) f[1+k] = d[k];
`ifdef UART_TX_PARITY_EN
      f[9] = pe ^ PARITY_ODD;
`else
      if (pe) f[15] = 1'b1;
`endif
      return f;
   endfunction

   task automatic check_frame(input string name, input logic [7:0] data, input logic par_even,
                              input int inj_clk, input logic [7:0] inj_data);
      logic [15:0]  bits;
      logic [255:0] obs, exp;
      int nclk, busy_n, clr_n, done_n;
      logic clr_first;
      bits = build_frame(data, par_even);
      nclk = 4 * FLEN1;
      obs = '0; exp = '0; busy_n = 0; clr_n = 0; done_n = 0; clr_first = 1'b0;
      tx_data = data;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      for (int c = 0; c < nclk; c++) begin
         obs[c] = tx;
         exp[c] = bits[c/4];
         busy_n += int'(tx_busy);
         clr_n  += int'(bit_clr);
         done_n += int'(tx_done);
         if (c == 0) clr_first = bit_clr;
         if (c == inj_clk) begin
            tx_start = 1'b1;
            tx_data  = inj_data;
         end else begin
            tx_start = 1'b0;
         end
         @(negedge clk);
      end
      tx_start = 1'b0;
      check({name, " tx"}, obs, exp);
      check({name, " busy clocks"}, 256'(busy_n), 256'(nclk));
      check({name, " clr"}, {255'(clr_n), clr_first}, {255'd1, 1'b1});
      check({name, " early done"}, 256'(done_n), 256'd0);
      check({name, " end tx/busy/done/en"}, {252'd0, tx, tx_busy, tx_done, bit_en}, 256'b1010);
      @(negedge clk);
      check({name, " idle tx/busy/done/en"}, {252'd0, tx, tx_busy, tx_done, bit_en}, 256'b1000);
   endtask

   initial begin
      logic [15:0]  f1, f2;
      logic [255:0] obs, exp;
      int n, done_n, first_done;

      vecs[0] = '{"a5", 8'hA5, 1'b0};
      vecs[1] = '{"00", 8'h00, 1'b0};
      vecs[2] = '{"ff", 8'hFF, 1'b0};
      vecs[3] = '{"07", 8'h07, 1'b1};
      vecs[4] = '{"01", 8'h01, 1'b1};
      vecs[5] = '{"80", 8'h80, 1'b1};
      vecs[6] = '{"3c", 8'h3C, 1'b0};

      // Reset held with tx_start high: no frame may start.
      rst = 1'b1;
      tx_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset outputs", {252'd0, tx, tx_busy, tx_done, bit_en}, 256'b1000);
      end
      rst = 1'b0;
      tx_start = 1'b0;
      @(negedge clk);
      check("post-reset idle", {252'd0, tx, tx_busy, tx_done, bit_en}, 256'b1000);

      spur = 1'b1;
      @(negedge clk);
      @(negedge clk);
      spur = 1'b0;
      check("spurious end in idle", {251'd0, tx, tx_busy, tx_done, bit_en, bit_clr}, 256'b10000);

      for (int i = 0; i < 7; i++) check_frame(vecs[i].name, vecs[i].data, vecs[i].par_even, -1, 8'h00);

      check_frame("busy reject", 8'h00, 1'b0, 13, 8'hFF);

      // Two stop bits, tx_start held high: 0x55 then 0x0F with a single idle clock between.
      f1 = build_frame(8'h55, 1'b0);
      f2 = build_frame(8'h0F, 1'b0);
      n = 8 * FLEN2 + 1;
      obs = '0; exp = '0; done_n = 0; first_done = -1;
      tx_data2 = 8'h55;
      tx_start2 = 1'b1;
      @(negedge clk);
      tx_data2 = 8'h0F;
      for (int c = 0; c < n; c++) begin
         obs[c] = tx2;
         if (c < 4 * FLEN2)       exp[c] = f1[c/4];
         else if (c == 4 * FLEN2) exp[c] = 1'b1;
         else                     exp[c] = f2[(c - 4 * FLEN2 - 1) / 4];
         if (tx_done2) begin
            done_n++;
            if (first_done < 0) first_done = c;
         end
         if (c == 4 * FLEN2) check("b2b gap busy", {255'd0, tx_busy2}, 256'd0);
         if (c == 4 * FLEN2 + 1) tx_start2 = 1'b0;
         @(negedge clk);
      end
      check("b2b tx stream", obs, exp);
      check("b2b first done", 256'(first_done), 256'(4 * FLEN2));
      check("b2b done count", 256'(done_n), 256'd1);
      check("b2b second done", {255'd0, tx_done2}, 256'd1);
      @(negedge clk);
      check("b2b idle after", {253'd0, tx2, tx_busy2, tx_done2}, 256'b100);

      // Reset during data bit 4 of 0xA5 aborts the frame without tx_done.
      tx_data = 8'hA5;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      for (int c = 0; c < 21; c++) @(negedge clk);
      check("pre-abort busy", {255'd0, tx_busy}, 256'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort outputs", {252'd0, tx, tx_busy, tx_done, bit_en}, 256'b1000);
      rst = 1'b0;
      done_n = 0;
      obs = '0;
      for (int c = 0; c < 50; c++) begin
         done_n += int'(tx_done);
         obs[c] = tx;
         @(negedge clk);
      end
      check("abort no done", 256'(done_n), 256'd0);
      check("abort line idle", obs[49:0], {50{1'b1}});
      check_frame("after abort", 8'hA5, 1'b0, -1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
